// File: rtl/multicycle_computer_xpsr_cond.sv
// multicycle_computer_xpsr_cond
// Status register (N,Z,C,V) plus condition-check unit for the multicycle
// computer. Flags load from the ALU on the controller's flagUpdate strobe.
// The instruction condition is evaluated and latched at decode. The latched
// result then gates the architectural write enables.
// Optional build macro: XPSR_COND_STATS_EN adds the execCount/skipCount
// statistics counters and their output ports.
// Interface: no handshakes; the unit never applies back-pressure.
module multicycle_computer_xpsr_cond #(
    parameter int         COND_HI  = 31,
    parameter logic [3:0] S_FETCH  = 4'b0000,
    parameter logic [3:0] S_DECODE = 4'b0001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  state,
    input  logic [31:0] INSTRUCTION,
    input  logic        flagUpdate,
    input  logic [3:0]  ALUFlags,
    input  logic        RegWrite_in,
    input  logic        MemWrite_in,
    input  logic        PCWrite_in,
    output logic [3:0]  Flags,
`ifdef XPSR_COND_STATS_EN
    output logic [15:0] execCount,
    output logic [15:0] skipCount,
`endif
    output logic        CondEx,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic        PCWrite
);

    logic [3:0] cond;
    logic       cond_pass;
    logic       flag_n, flag_z, flag_c, flag_v;
    logic       ungated;

    assign cond = INSTRUCTION[COND_HI -: 4];
    assign {flag_n, flag_z, flag_c, flag_v} = Flags;

    // Condition evaluation against the currently stored flags.
    always_comb begin
        cond_pass = 1'b1;
        case (cond)
            4'b0000: cond_pass = flag_z;
            4'b0001: cond_pass = !flag_z;
            4'b0010: cond_pass = flag_c;
            4'b0011: cond_pass = !flag_c;
            4'b0100: cond_pass = flag_n;
            4'b0101: cond_pass = !flag_n;
            4'b0110: cond_pass = flag_v;
            4'b0111: cond_pass = !flag_v;
            4'b1000: cond_pass = flag_c && !flag_z;
            4'b1001: cond_pass = !flag_c || flag_z;
            4'b1010: cond_pass = (flag_n == flag_v);
            4'b1011: cond_pass = (flag_n != flag_v);
            4'b1100: cond_pass = !flag_z && (flag_n == flag_v);
            4'b1101: cond_pass = flag_z || (flag_n != flag_v);
            default: cond_pass = 1'b1;  // AL and the unconditional 1111 code
        endcase
    end

    // Flag register: a skipped instruction (CondEx=0) cannot alter flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            Flags <= 4'b0000;
        end else if (flagUpdate && CondEx) begin
            Flags <= ALUFlags;
        end
    end

    // Condition latch: captured at decode, held for the rest of the instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            CondEx <= 1'b1;
        end else if (state == S_DECODE) begin
            CondEx <= cond_pass;
        end
    end

    // Write-enable gating; fetch and decode are never suppressed.
    always_comb begin
        ungated  = (state == S_FETCH) || (state == S_DECODE);
        RegWrite = RegWrite_in & (ungated | CondEx);
        MemWrite = MemWrite_in & (ungated | CondEx);
        PCWrite  = PCWrite_in  & (ungated | CondEx);
    end

`ifdef XPSR_COND_STATS_EN
    // Saturating pass/skip counters, advanced once per decode edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            execCount <= 16'h0000;
            skipCount <= 16'h0000;
        end else if (state == S_DECODE) begin
            if (cond_pass) begin
                if (execCount != 16'hFFFF) execCount <= execCount + 16'h0001;
            end else begin
                if (skipCount != 16'hFFFF) skipCount <= skipCount + 16'h0001;
            end
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_computer_xpsr_cond.sv
// Bench for multicycle_computer_xpsr_cond.
// Inputs change on the falling edge. Outputs are sampled 1 ns later, which
// is away from the rising edge. Each sample therefore shows registers as left
// by earlier edges and the gated enables for the inputs currently applied.
// Packed observation vector: {Flags[3:0], CondEx, RegWrite, MemWrite, PCWrite}.
module tb_multicycle_computer_xpsr_cond;

    localparam logic [3:0] S_FETCH  = 4'b0000;
    localparam logic [3:0] S_DECODE = 4'b0001;
    localparam logic [3:0] S_EXA    = 4'b0110;
    localparam logic [3:0] S_EXB    = 4'b0111;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  state;
    logic [31:0] INSTRUCTION;
    logic        flagUpdate;
    logic [3:0]  ALUFlags;
    logic        RegWrite_in, MemWrite_in, PCWrite_in;
    logic [3:0]  Flags;
    logic        CondEx, RegWrite, MemWrite, PCWrite;
`ifdef XPSR_COND_STATS_EN
    logic [15:0] execCount, skipCount;
`endif

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];

    // Clock generation.
    always #5 clk = ~clk;

    multicycle_computer_xpsr_cond dut (
        .clk         (clk),
        .reset       (reset),
        .state       (state),
        .INSTRUCTION (INSTRUCTION),
        .flagUpdate  (flagUpdate),
        .ALUFlags    (ALUFlags),
        .RegWrite_in (RegWrite_in),
        .MemWrite_in (MemWrite_in),
        .PCWrite_in  (PCWrite_in),
        .Flags       (Flags),
`ifdef XPSR_COND_STATS_EN
        .execCount   (execCount),
        .skipCount   (skipCount),
`endif
        .CondEx      (CondEx),
        .RegWrite    (RegWrite),
        .MemWrite    (MemWrite),
        .PCWrite     (PCWrite)
    );

    typedef struct {
        string      name;
        logic       rst;
        logic [3:0] st;
        logic [3:0] cd;
        logic       fu;
        logic [3:0] alu;
        logic       rwi, mwi, pwi;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[17];

    // Reference ARM condition table, written out from the flag definitions.
    function automatic logic cond_model(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        case (c)
            4'd0:  return z == 1'b1;
            4'd1:  return z == 1'b0;
            4'd2:  return cf == 1'b1;
            4'd3:  return cf == 1'b0;
            4'd4:  return n == 1'b1;
            4'd5:  return n == 1'b0;
            4'd6:  return v == 1'b1;
            4'd7:  return v == 1'b0;
            4'd8:  return (cf == 1'b1) && (z == 1'b0);
            4'd9:  return (cf == 1'b0) || (z == 1'b1);
            4'd10: return n ~^ v;
            4'd11: return n ^ v;
            4'd12: return (z == 1'b0) && (n ~^ v);
            4'd13: return (z == 1'b1) || (n ^ v);
            default: return 1'b1;
        endcase
    endfunction

    // Apply one cycle of inputs; optionally queue an expectation and check it.
    task automatic drive(input string nm, input logic rst, input logic [3:0] st,
                         input logic [3:0] cd, input logic fu, input logic [3:0] alu,
                         input logic rwi, input logic mwi, input logic pwi,
                         input logic chk, input logic [7:0] exp);
        logic [7:0] got;
        logic [7:0] e;
        reset       = rst;
        state       = st;
        INSTRUCTION = {cd, 28'($urandom_range(0, 32'h0FFF_FFFF))};
        flagUpdate  = fu;
        ALUFlags    = alu;
        RegWrite_in = rwi;
        MemWrite_in = mwi;
        PCWrite_in  = pwi;
        if (chk) exp_q.push_back(exp);
        #1;
        if (chk) begin
            got = {Flags, CondEx, RegWrite, MemWrite, PCWrite};
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL %s: got flags=%b condex=%b rw/mw/pw=%b%b%b, expected flags=%b condex=%b rw/mw/pw=%b%b%b",
                         nm, got[7:4], got[3], got[2], got[1], got[0],
                         e[7:4], e[3], e[2], e[1], e[0]);
            end
        end
        @(negedge clk);
    endtask

`ifdef XPSR_COND_STATS_EN
    task automatic check_cnt(input string nm, input logic [15:0] got, input logic [15:0] e);
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, got, e);
        end
    endtask
`endif

    // Stimulus and checking.
    initial begin
        logic [3:0] fvals[5];
        logic       p;
        fvals[0] = 4'b0000; fvals[1] = 4'b1000; fvals[2] = 4'b0010;
        fvals[3] = 4'b1001; fvals[4] = 4'b0110;

        //          name            rst  state     cond    fu   alu      rw  mw  pw   {flags,cx,rw,mw,pw}
        vecs[0]  = '{"reset_idle",   0, S_FETCH,  4'hE, 0, 4'b0000, 1, 0, 0, 8'b0000_1_100};
        vecs[1]  = '{"flag_load",    0, S_EXA,    4'hE, 1, 4'b0100, 0, 0, 0, 8'b0000_1_000};
        vecs[2]  = '{"dec_eq",       0, S_DECODE, 4'h0, 0, 4'b0000, 1, 0, 0, 8'b0100_1_100};
        vecs[3]  = '{"eq_pass_rw",   0, S_EXB,    4'hE, 0, 4'b0000, 1, 0, 0, 8'b0100_1_100};
        vecs[4]  = '{"fetch_pc",     0, S_FETCH,  4'hE, 0, 4'b0000, 0, 0, 1, 8'b0100_1_001};
        vecs[5]  = '{"dec_ne",       0, S_DECODE, 4'h1, 0, 4'b0000, 0, 0, 1, 8'b0100_1_001};
        vecs[6]  = '{"ne_fail_gate", 0, S_EXB,    4'hE, 0, 4'b0000, 1, 1, 1, 8'b0100_0_000};
        vecs[7]  = '{"skip_fu",      0, S_EXA,    4'hE, 1, 4'b1001, 0, 0, 0, 8'b0100_0_000};
        vecs[8]  = '{"fetch_ungated",0, S_FETCH,  4'hE, 0, 4'b0000, 0, 0, 1, 8'b0100_0_001};
        vecs[9]  = '{"dec_pass_thru",0, S_DECODE, 4'hE, 0, 4'b0000, 0, 1, 0, 8'b0100_0_010};
        vecs[10] = '{"al_mw",        0, S_EXB,    4'hE, 0, 4'b0000, 0, 1, 0, 8'b0100_1_010};
        vecs[11] = '{"dec_ne2",      0, S_DECODE, 4'h1, 0, 4'b0000, 0, 0, 0, 8'b0100_1_000};
        vecs[12] = '{"pre_reset",    1, S_EXB,    4'hE, 0, 4'b0000, 1, 0, 0, 8'b0100_0_000};
        vecs[13] = '{"post_reset",   0, S_FETCH,  4'hE, 0, 4'b0000, 1, 0, 0, 8'b0000_1_100};
        vecs[14] = '{"post_rst_ex",  0, S_EXB,    4'hE, 0, 4'b0000, 1, 0, 1, 8'b0000_1_101};
        vecs[15] = '{"dec_with_fu",  0, S_DECODE, 4'h0, 1, 4'b0100, 0, 0, 0, 8'b0000_1_000};
        vecs[16] = '{"dec_fu_after", 0, S_EXB,    4'hE, 0, 4'b0000, 0, 0, 0, 8'b0100_0_000};

        // Reset block: hold reset across two rising edges.
        reset = 1'b1; state = S_FETCH; INSTRUCTION = '0; flagUpdate = 1'b0;
        ALUFlags = '0; RegWrite_in = 1'b0; MemWrite_in = 1'b0; PCWrite_in = 1'b0;
        repeat (2) @(negedge clk);

        // Directed table.
        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].name, vecs[i].rst, vecs[i].st, vecs[i].cd, vecs[i].fu,
                  vecs[i].alu, vecs[i].rwi, vecs[i].mwi, vecs[i].pwi, 1'b1, vecs[i].exp);
        end

        // Condition sweep: 16 codes against five flag patterns.
        for (int k = 0; k < 5; k++) begin
            drive("sweep_al", 0, S_DECODE, 4'hE, 0, 4'b0000, 0, 0, 0, 1'b0, 8'h00);
            drive("sweep_load", 0, S_EXA, 4'hE, 1, fvals[k], 0, 0, 0, 1'b0, 8'h00);
            for (int c = 0; c < 16; c++) begin
                p = cond_model(4'(c), fvals[k]);
                drive("sweep_dec", 0, S_DECODE, 4'(c), 0, 4'b0000, 0, 0, 0, 1'b0, 8'h00);
                drive($sformatf("sweep_f%b_c%0d", fvals[k], c), 0, S_EXB, 4'hE, 0, 4'b0000,
                      1, 0, 0, 1'b1, {fvals[k], p, p, 1'b0, 1'b0});
            end
        end

`ifdef XPSR_COND_STATS_EN
        // Statistics: 3 passes and 2 fails after reset (Flags=0, so EQ fails).
        drive("st_rst", 1, S_FETCH, 4'hE, 0, 4'b0000, 0, 0, 0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++)
            drive("st_pass", 0, S_DECODE, 4'hE, 0, 4'b0000, 0, 0, 0, 1'b0, 8'h00);
        for (int i = 0; i < 2; i++)
            drive("st_fail", 0, S_DECODE, 4'h0, 0, 4'b0000, 0, 0, 0, 1'b0, 8'h00);
        drive("st_idle", 0, S_EXB, 4'hE, 0, 4'b0000, 0, 0, 0, 1'b0, 8'h00);
        #1;
        check_cnt("exec_3", execCount, 16'd3);
        check_cnt("skip_2", skipCount, 16'd2);
        for (int i = 0; i < 65532; i++)
            drive("st_fill", 0, S_DECODE, 4'hE, 0, 4'b0000, 0, 0, 0, 1'b0, 8'h00);
        drive("st_idle", 0, S_EXB, 4'hE, 0, 4'b0000, 0, 0, 0, 1'b0, 8'h00);
        #1;
        check_cnt("exec_full", execCount, 16'hFFFF);
        for (int i = 0; i < 2; i++)
            drive("st_sat", 0, S_DECODE, 4'hE, 0, 4'b0000, 0, 0, 0, 1'b0, 8'h00);
        drive("st_idle", 0, S_EXB, 4'hE, 0, 4'b0000, 0, 0, 0, 1'b0, 8'h00);
        #1;
        check_cnt("exec_sat", execCount, 16'hFFFF);
        check_cnt("skip_hold", skipCount, 16'd2);
`endif

        // Final report.
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
